// File: rtl/vreg_pkg.sv
`default_nettype none
// ============================================================================
// Module   : vreg_pkg
// Brief    : Shared encodings and helpers for the vreg_file register file.
// Revision : 1.0
// ============================================================================
package vreg_pkg;

    localparam logic [2:0] CS_REQUEST = 3'b011;
    localparam logic [2:0] CS_UPDATE  = 3'b110;

    typedef enum logic [1:0] {
        MUX_ARITH  = 2'd0,
        MUX_MEMORY = 2'd1,
        MUX_CONST  = 2'd2
    } reg_mux_e;

    // One lane at the default width; also the width of the id inputs.
    typedef logic [7:0] lane_t;

    function automatic logic addr_writable(input int addr, input int num_w);
        return addr < num_w;
    endfunction

endpackage
`default_nettype wire

// File: rtl/vreg_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : vreg_scoreboard
// Brief    : Pending-load bits for the scalar and vector banks, with lookup.
// Revision : 1.0
// ============================================================================
module vreg_scoreboard
    import vreg_pkg::*;
#(
    parameter int NUM_W     = 13,
    parameter int ADDR_BITS = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 set_en,
    input  logic                 set_vec,
    input  logic [ADDR_BITS-1:0] set_addr,
    input  logic                 clr_en,
    input  logic                 clr_vec,
    input  logic [ADDR_BITS-1:0] clr_addr,
    input  logic                 look_vec,
    input  logic [ADDR_BITS-1:0] rs_addr,
    input  logic [ADDR_BITS-1:0] rt_addr,
    input  logic [ADDR_BITS-1:0] rd_addr,
    output logic                 rs_pend,
    output logic                 rt_pend,
    output logic                 rd_pend
);

    logic [NUM_W-1:0] pend_s_q, pend_s_d;
    logic [NUM_W-1:0] pend_v_q, pend_v_d;

    // Clear before set: a same-cycle writeback and new load leave the bit set.
    always_comb begin
        pend_s_d = pend_s_q;
        pend_v_d = pend_v_q;
        if (clr_en && addr_writable(int'(clr_addr), NUM_W)) begin
            if (clr_vec) pend_v_d[clr_addr] = 1'b0;
            else         pend_s_d[clr_addr] = 1'b0;
        end
        if (set_en && addr_writable(int'(set_addr), NUM_W)) begin
            if (set_vec) pend_v_d[set_addr] = 1'b1;
            else         pend_s_d[set_addr] = 1'b1;
        end
    end

    always_comb begin
        rs_pend = 1'b0;
        rt_pend = 1'b0;
        rd_pend = 1'b0;
        if (addr_writable(int'(rs_addr), NUM_W))
            rs_pend = look_vec ? pend_v_q[rs_addr] : pend_s_q[rs_addr];
        if (addr_writable(int'(rt_addr), NUM_W))
            rt_pend = look_vec ? pend_v_q[rt_addr] : pend_s_q[rt_addr];
        if (addr_writable(int'(rd_addr), NUM_W))
            rd_pend = look_vec ? pend_v_q[rd_addr] : pend_s_q[rd_addr];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pend_s_q <= '0;
            pend_v_q <= '0;
        end else begin
            pend_s_q <= pend_s_d;
            pend_v_q <= pend_v_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/vreg_file.sv
`default_nettype none
// ============================================================================
// Module   : vreg_file
// Brief    : Scalar + vector register file with pending-load scoreboard.
//            Optional writeback forwarding when VREG_BYPASS_EN is defined.
// Revision : 1.0
// ============================================================================
module vreg_file
    import vreg_pkg::*;
#(
    parameter int DATA_BITS   = 8,
    parameter int VECTOR_SIZE = 4,
    parameter int NUM_REGS    = 16,
    parameter int NUM_RO      = 3,
    parameter int ADDR_BITS   = $clog2(NUM_REGS)
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             enable,
    input  lane_t                            core_id,
    input  lane_t                            engine_id,
    input  lane_t                            task_id,
    input  logic [2:0]                       core_state,
    input  logic [ADDR_BITS-1:0]             rd_addr,
    input  logic [ADDR_BITS-1:0]             rs_addr,
    input  logic [ADDR_BITS-1:0]             rt_addr,
    input  logic                             reg_write_enable,
    input  logic [1:0]                       reg_input_mux,
    input  logic                             vector_mux,
    input  logic [DATA_BITS-1:0]             immediate,
    input  logic [VECTOR_SIZE-1:0]           lane_mask,
    input  logic [DATA_BITS-1:0]             alu_out,
    input  logic [VECTOR_SIZE*DATA_BITS-1:0] v_alu_out,
    input  logic                             lsu_wb_valid,
    output logic                             lsu_wb_ready,
    input  logic                             lsu_wb_vector,
    input  logic [ADDR_BITS-1:0]             lsu_wb_addr,
    input  logic [VECTOR_SIZE*DATA_BITS-1:0] lsu_wb_data,
    output logic [DATA_BITS-1:0]             rs,
    output logic [DATA_BITS-1:0]             rt,
    output logic [VECTOR_SIZE*DATA_BITS-1:0] v_rs,
    output logic [VECTOR_SIZE*DATA_BITS-1:0] v_rt,
    output logic                             operands_valid,
    output logic                             hazard
);

    localparam int VW    = VECTOR_SIZE * DATA_BITS;
    localparam int NUM_W = NUM_REGS - NUM_RO;

    logic [DATA_BITS-1:0] sregs_q [NUM_REGS];
    logic [DATA_BITS-1:0] sregs_d [NUM_REGS];
    logic [DATA_BITS-1:0] ro_init [NUM_REGS];
    logic [VW-1:0]        vregs_q [NUM_W];
    logic [VW-1:0]        vregs_d [NUM_W];

    logic [DATA_BITS-1:0] rs_q, rs_d, rt_q, rt_d;
    logic [VW-1:0]        v_rs_q, v_rs_d, v_rt_q, v_rt_d;
    logic                 operands_valid_q, operands_valid_d;

    logic is_req, is_upd, core_wr_s, core_wr_v, mem_set, wb_fire, wb_ok;
    logic rs_pend, rt_pend, rd_pend, fwd_rs, fwd_rt;
    logic [DATA_BITS-1:0] s_rs_rd, s_rt_rd;
    logic [VW-1:0]        v_rs_rd, v_rt_rd;

    assign is_req    = enable && (core_state == CS_REQUEST);
    assign is_upd    = enable && (core_state == CS_UPDATE) && reg_write_enable
                       && addr_writable(int'(rd_addr), NUM_W);
    assign core_wr_s = is_upd && !vector_mux
                       && (reg_input_mux == MUX_ARITH || reg_input_mux == MUX_CONST);
    assign core_wr_v = is_upd && vector_mux && (reg_input_mux == MUX_ARITH);
    assign mem_set   = is_upd && (reg_input_mux == MUX_MEMORY);

    // The core's data write owns the bank's write port this cycle.
    assign lsu_wb_ready = lsu_wb_vector ? !core_wr_v : !core_wr_s;
    assign wb_fire      = lsu_wb_valid && lsu_wb_ready;
    assign wb_ok        = wb_fire && addr_writable(int'(lsu_wb_addr), NUM_W);

    vreg_scoreboard #(
        .NUM_W     (NUM_W),
        .ADDR_BITS (ADDR_BITS)
    ) u_scoreboard (
        .clk      (clk),
        .reset    (reset),
        .set_en   (mem_set),
        .set_vec  (vector_mux),
        .set_addr (rd_addr),
        .clr_en   (wb_fire),
        .clr_vec  (lsu_wb_vector),
        .clr_addr (lsu_wb_addr),
        .look_vec (vector_mux),
        .rs_addr  (rs_addr),
        .rt_addr  (rt_addr),
        .rd_addr  (rd_addr),
        .rs_pend  (rs_pend),
        .rt_pend  (rt_pend),
        .rd_pend  (rd_pend)
    );

`ifdef VREG_BYPASS_EN
    assign fwd_rs = wb_ok && (lsu_wb_vector == vector_mux) && (lsu_wb_addr == rs_addr);
    assign fwd_rt = wb_ok && (lsu_wb_vector == vector_mux) && (lsu_wb_addr == rt_addr);
`else
    assign fwd_rs = 1'b0;
    assign fwd_rt = 1'b0;
`endif

    assign hazard = is_req && ((rs_pend && !fwd_rs) || (rt_pend && !fwd_rt)
                               || (reg_write_enable && rd_pend));

    always_comb begin
        s_rs_rd = sregs_q[rs_addr];
        s_rt_rd = sregs_q[rt_addr];
        v_rs_rd = '0;
        v_rt_rd = '0;
        if (addr_writable(int'(rs_addr), NUM_W)) v_rs_rd = vregs_q[rs_addr];
        if (addr_writable(int'(rt_addr), NUM_W)) v_rt_rd = vregs_q[rt_addr];
        if (fwd_rs) begin
            s_rs_rd = lsu_wb_data[DATA_BITS-1:0];
            v_rs_rd = lsu_wb_data;
        end
        if (fwd_rt) begin
            s_rt_rd = lsu_wb_data[DATA_BITS-1:0];
            v_rt_rd = lsu_wb_data;
        end
    end

    always_comb begin
        rs_d             = rs_q;
        rt_d             = rt_q;
        v_rs_d           = v_rs_q;
        v_rt_d           = v_rt_q;
        operands_valid_d = 1'b0;
        if (is_req && !hazard) begin
            operands_valid_d = 1'b1;
            if (vector_mux) begin
                v_rs_d = v_rs_rd;
                v_rt_d = v_rt_rd;
            end else begin
                rs_d = s_rs_rd;
                rt_d = s_rt_rd;
            end
        end
    end

    always_comb begin
        sregs_d = sregs_q;
        vregs_d = vregs_q;
        if (wb_ok) begin
            if (lsu_wb_vector) vregs_d[lsu_wb_addr] = lsu_wb_data;
            else               sregs_d[lsu_wb_addr] = lsu_wb_data[DATA_BITS-1:0];
        end
        if (core_wr_s)
            sregs_d[rd_addr] = (reg_input_mux == MUX_CONST) ? immediate : alu_out;
        if (core_wr_v) begin
            for (int l = 0; l < VECTOR_SIZE; l++) begin
                if (lane_mask[l])
                    vregs_d[rd_addr][l*DATA_BITS +: DATA_BITS] = v_alu_out[l*DATA_BITS +: DATA_BITS];
            end
        end
    end

    // Read-only registers sit at the top of the scalar bank.
    always_comb begin
        for (int i = 0; i < NUM_REGS; i++) begin
            if (i == NUM_W)          ro_init[i] = DATA_BITS'(core_id);
            else if (i == NUM_W + 1) ro_init[i] = DATA_BITS'(engine_id);
            else if (i == NUM_W + 2) ro_init[i] = DATA_BITS'(task_id);
            else                     ro_init[i] = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) sregs_q[i] <= ro_init[i];
            for (int i = 0; i < NUM_W; i++)    vregs_q[i] <= '0;
            rs_q             <= '0;
            rt_q             <= '0;
            v_rs_q           <= '0;
            v_rt_q           <= '0;
            operands_valid_q <= 1'b0;
        end else begin
            sregs_q          <= sregs_d;
            vregs_q          <= vregs_d;
            rs_q             <= rs_d;
            rt_q             <= rt_d;
            v_rs_q           <= v_rs_d;
            v_rt_q           <= v_rt_d;
            operands_valid_q <= operands_valid_d;
        end
    end

    assign rs             = rs_q;
    assign rt             = rt_q;
    assign v_rs           = v_rs_q;
    assign v_rt           = v_rt_q;
    assign operands_valid = operands_valid_q;

endmodule
`default_nettype wire

// File: tb/tb_vreg_file.sv
`default_nettype none
// ============================================================================
// Module   : tb_vreg_file
// Brief    : Directed vector table, reset corner case and randomized run
//            against a bank/array reference model of vreg_file.
// Revision : 1.0
// ============================================================================
module tb_vreg_file;

    localparam int NW = 13;
`ifdef VREG_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif
    localparam logic [2:0] R = 3'b011;
    localparam logic [2:0] U = 3'b110;
    localparam logic [2:0] I = 3'b000;

    logic        clk = 1'b0;
    logic        reset, enable, reg_write_enable, vector_mux;
    logic [7:0]  core_id, engine_id, task_id, immediate, alu_out, rs, rt;
    logic [2:0]  core_state;
    logic [3:0]  rd_addr, rs_addr, rt_addr, lane_mask, lsu_wb_addr;
    logic [1:0]  reg_input_mux;
    logic [31:0] v_alu_out, lsu_wb_data, v_rs, v_rt;
    logic        lsu_wb_valid, lsu_wb_ready, lsu_wb_vector, operands_valid, hazard;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    vreg_file dut (
        .clk(clk), .reset(reset), .enable(enable),
        .core_id(core_id), .engine_id(engine_id), .task_id(task_id),
        .core_state(core_state), .rd_addr(rd_addr), .rs_addr(rs_addr), .rt_addr(rt_addr),
        .reg_write_enable(reg_write_enable), .reg_input_mux(reg_input_mux),
        .vector_mux(vector_mux), .immediate(immediate), .lane_mask(lane_mask),
        .alu_out(alu_out), .v_alu_out(v_alu_out),
        .lsu_wb_valid(lsu_wb_valid), .lsu_wb_ready(lsu_wb_ready),
        .lsu_wb_vector(lsu_wb_vector), .lsu_wb_addr(lsu_wb_addr), .lsu_wb_data(lsu_wb_data),
        .rs(rs), .rt(rt), .v_rs(v_rs), .v_rt(v_rt),
        .operands_valid(operands_valid), .hazard(hazard)
    );

    typedef struct {
        logic en; logic [2:0] cs; logic vec; logic we; logic [1:0] mux;
        logic [3:0] rd; logic [3:0] rs; logic [3:0] rt; logic [31:0] data; logic [3:0] mask;
        logic wbv; logic wbvec; logic [3:0] wba; logic [31:0] wbd;
        logic e_hz; logic e_rdy; logic [7:0] e_rs; logic [7:0] e_rt; logic [31:0] e_vrs; logic e_ov;
    } vec_t;

    function automatic vec_t mk(input logic [2:0] cs, input logic vec, input logic we,
                                input logic [1:0] mux, input logic [3:0] rd, input logic [3:0] ra,
                                input logic [3:0] rb, input logic [31:0] data, input logic [3:0] mask,
                                input logic wbv, input logic wbvec, input logic [3:0] wba,
                                input logic [31:0] wbd, input logic hz, input logic rdy,
                                input logic [7:0] ers, input logic [7:0] ert,
                                input logic [31:0] evrs, input logic eov);
        vec_t v;
        v.en = 1'b1; v.cs = cs; v.vec = vec; v.we = we; v.mux = mux;
        v.rd = rd; v.rs = ra; v.rt = rb; v.data = data; v.mask = mask;
        v.wbv = wbv; v.wbvec = wbvec; v.wba = wba; v.wbd = wbd;
        v.e_hz = hz; v.e_rdy = rdy; v.e_rs = ers; v.e_rt = ert; v.e_vrs = evrs; v.e_ov = eov;
        return v;
    endfunction

    task automatic drive(input vec_t v);
        enable = v.en; core_state = v.cs; vector_mux = v.vec; reg_write_enable = v.we;
        reg_input_mux = v.mux; rd_addr = v.rd; rs_addr = v.rs; rt_addr = v.rt;
        immediate = v.data[7:0]; alu_out = v.data[7:0]; v_alu_out = v.data; lane_mask = v.mask;
        lsu_wb_valid = v.wbv; lsu_wb_vector = v.wbvec; lsu_wb_addr = v.wba; lsu_wb_data = v.wbd;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%h required=%h", name, act, exp);
        end
    endtask

    vec_t idle;

    task automatic do_reset();
        reset = 1'b1;
        drive(idle);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    // ---------------- reference model: two banks of 16 registers ----------------
    logic [31:0] m_reg  [2][16];
    bit          m_pend [2][16];
    logic [7:0]  m_rs, m_rt;
    logic [31:0] m_vrs, m_vrt;
    bit          m_ov;

    function automatic bit writable(input logic [3:0] a);
        return int'(a) < NW;
    endfunction

    function automatic bit core_writes(input logic bank);
        return enable && core_state == U && reg_write_enable && writable(rd_addr)
               && vector_mux == bank
               && (reg_input_mux == 2'd0 || (reg_input_mux == 2'd2 && bank == 1'b0));
    endfunction

    function automatic bit exp_ready();
        return !core_writes(lsu_wb_vector);
    endfunction

    function automatic bit fwd(input logic [3:0] a);
        return BYP && lsu_wb_valid && exp_ready() && lsu_wb_vector == vector_mux
               && lsu_wb_addr == a && writable(a);
    endfunction

    function automatic bit exp_hazard();
        return enable && core_state == R
               && ((m_pend[vector_mux][rs_addr] && !fwd(rs_addr))
                   || (m_pend[vector_mux][rt_addr] && !fwd(rt_addr))
                   || (reg_write_enable && m_pend[vector_mux][rd_addr]));
    endfunction

    function automatic logic [31:0] read_src(input logic [3:0] a);
        if (fwd(a)) return vector_mux ? lsu_wb_data : {24'h0, lsu_wb_data[7:0]};
        return m_reg[vector_mux][a];
    endfunction

    task automatic model_reset();
        for (int b = 0; b < 2; b++)
            for (int a = 0; a < 16; a++) begin
                m_reg[b][a] = '0;
                m_pend[b][a] = 1'b0;
            end
        m_reg[0][13] = {24'h0, core_id};
        m_reg[0][14] = {24'h0, engine_id};
        m_reg[0][15] = {24'h0, task_id};
        m_rs = '0; m_rt = '0; m_vrs = '0; m_vrt = '0; m_ov = 1'b0;
    endtask

    task automatic model_update();
        bit fire;
        logic [31:0] a_val, b_val;
        fire = lsu_wb_valid && exp_ready();
        m_ov = 1'b0;
        if (enable && core_state == R && !exp_hazard()) begin
            m_ov  = 1'b1;
            a_val = read_src(rs_addr);
            b_val = read_src(rt_addr);
            if (vector_mux) begin m_vrs = a_val; m_vrt = b_val; end
            else begin m_rs = a_val[7:0]; m_rt = b_val[7:0]; end
        end
        if (fire && writable(lsu_wb_addr)) begin
            m_reg[lsu_wb_vector][lsu_wb_addr]  = lsu_wb_vector ? lsu_wb_data : {24'h0, lsu_wb_data[7:0]};
            m_pend[lsu_wb_vector][lsu_wb_addr] = 1'b0;
        end
        if (enable && core_state == U && reg_write_enable && writable(rd_addr)) begin
            if (reg_input_mux == 2'd1)
                m_pend[vector_mux][rd_addr] = 1'b1;
            else if (reg_input_mux == 2'd0 && vector_mux) begin
                for (int l = 0; l < 4; l++)
                    if (lane_mask[l]) m_reg[1][rd_addr][l*8 +: 8] = v_alu_out[l*8 +: 8];
            end else if (reg_input_mux == 2'd0)
                m_reg[0][rd_addr] = {24'h0, alu_out};
            else if (reg_input_mux == 2'd2 && !vector_mux)
                m_reg[0][rd_addr] = {24'h0, immediate};
        end
    endtask

    function automatic logic [3:0] raddr();
        if ($urandom_range(0, 3) == 0) return 4'($urandom_range(0, 15));
        return 4'($urandom_range(0, 5));
    endfunction

    // ---------------- test sequence ----------------
    vec_t tbl [$];
    vec_t v;
    bit   e_hz, e_rdy;

    initial begin
        idle = mk(I, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
        idle.en = 1'b0;
        core_id = 8'h05; engine_id = 8'h02; task_id = 8'h09;

        tbl.push_back(mk(R,0,0,0, 0,13,15, 32'h0,4'h0, 0,0,0,32'h0, 0,1, 8'h05,8'h09,32'h0,1));
        tbl.push_back(mk(U,0,1,2, 3,0,0, 32'h7A,4'h0, 0,0,0,32'h0, 0,0, 8'h05,8'h09,32'h0,0));
        tbl.push_back(mk(R,0,0,0, 0,3,13, 32'h0,4'h0, 0,0,0,32'h0, 0,1, 8'h7A,8'h05,32'h0,1));
        tbl.push_back(mk(U,0,1,2, 14,0,0, 32'hFF,4'h0, 0,1,0,32'h0, 0,1, 8'h7A,8'h05,32'h0,0));
        tbl.push_back(mk(R,0,0,0, 0,14,3, 32'h0,4'h0, 0,0,0,32'h0, 0,1, 8'h02,8'h7A,32'h0,1));
        tbl.push_back(mk(U,1,1,0, 2,0,0, 32'h44332211,4'b0101, 0,0,0,32'h0, 0,1, 8'h02,8'h7A,32'h0,0));
        tbl.push_back(mk(R,1,0,0, 0,2,12, 32'h0,4'h0, 0,0,0,32'h0, 0,1, 8'h02,8'h7A,32'h00330011,1));
        tbl.push_back(mk(U,0,1,1, 4,0,0, 32'h0,4'h0, 0,0,0,32'h0, 0,1, 8'h02,8'h7A,32'h00330011,0));
        for (int k = 0; k < 3; k++)
            tbl.push_back(mk(R,0,0,0, 0,4,3, 32'h0,4'h0, 0,0,0,32'h0, 1,1, 8'h02,8'h7A,32'h00330011,0));
        tbl.push_back(mk(R,0,0,0, 0,4,3, 32'h0,4'h0, 1,0,4,32'h000000C3, !BYP,1,
                         BYP ? 8'hC3 : 8'h02, 8'h7A, 32'h00330011, BYP));
        tbl.push_back(mk(R,0,0,0, 0,4,3, 32'h0,4'h0, 0,0,0,32'h0, 0,1, 8'hC3,8'h7A,32'h00330011,1));
        tbl.push_back(mk(U,0,1,0, 1,0,0, 32'h11,4'h0, 1,0,6,32'h66, 0,0, 8'hC3,8'h7A,32'h00330011,0));
        tbl.push_back(mk(I,0,0,0, 0,0,0, 32'h0,4'h0, 1,0,6,32'h66, 0,1, 8'hC3,8'h7A,32'h00330011,0));
        tbl.push_back(mk(U,0,1,0, 7,0,0, 32'h77,4'h0, 1,1,6,32'hDEADBEEF, 0,1, 8'hC3,8'h7A,32'h00330011,0));
        tbl.push_back(mk(R,0,0,0, 0,1,6, 32'h0,4'h0, 0,0,0,32'h0, 0,1, 8'h11,8'h66,32'h00330011,1));
        tbl.push_back(mk(R,1,0,0, 0,6,0, 32'h0,4'h0, 0,0,0,32'h0, 0,1, 8'h11,8'h66,32'hDEADBEEF,1));
        v = mk(R,0,0,0, 0,7,7, 32'h0,4'h0, 0,0,0,32'h0, 0,1, 8'h11,8'h66,32'hDEADBEEF,0);
        v.en = 1'b0;
        tbl.push_back(v);
        tbl.push_back(mk(R,0,0,0, 0,7,7, 32'h0,4'h0, 0,0,0,32'h0, 0,1, 8'h77,8'h77,32'hDEADBEEF,1));

        // Reset state
        do_reset();
        chk("reset_rs", {24'h0, rs}, 32'h0);
        chk("reset_rt", {24'h0, rt}, 32'h0);
        chk("reset_v_rs", v_rs, 32'h0);
        chk("reset_v_rt", v_rt, 32'h0);
        chk("reset_ov", {31'h0, operands_valid}, 32'h0);
        @(negedge clk);
        chk("reset_hazard", {31'h0, hazard}, 32'h0);
        chk("reset_ready", {31'h0, lsu_wb_ready}, 32'h1);
        @(posedge clk); #1;

        // Directed table
        foreach (tbl[i]) begin
            drive(tbl[i]);
            @(negedge clk);
            chk($sformatf("row%0d_hazard", i), {31'h0, hazard}, {31'h0, tbl[i].e_hz});
            chk($sformatf("row%0d_ready", i), {31'h0, lsu_wb_ready}, {31'h0, tbl[i].e_rdy});
            @(posedge clk); #1;
            chk($sformatf("row%0d_rs", i), {24'h0, rs}, {24'h0, tbl[i].e_rs});
            chk($sformatf("row%0d_rt", i), {24'h0, rt}, {24'h0, tbl[i].e_rt});
            chk($sformatf("row%0d_v_rs", i), v_rs, tbl[i].e_vrs);
            chk($sformatf("row%0d_ov", i), {31'h0, operands_valid}, {31'h0, tbl[i].e_ov});
        end

        // Reset while a vector load is outstanding
        v = idle; v.en = 1; v.cs = U; v.vec = 1; v.we = 1; v.mux = 2'd1; v.rd = 5;
        drive(v);
        @(posedge clk); #1;
        v = idle; v.en = 1; v.cs = R; v.vec = 1; v.rs = 5;
        drive(v);
        @(negedge clk);
        chk("midrst_hazard_pending", {31'h0, hazard}, 32'h1);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        chk("midrst_hazard_after", {31'h0, hazard}, 32'h0);
        @(posedge clk); #1;
        chk("midrst_v_rs", v_rs, 32'h0);
        chk("midrst_rs", {24'h0, rs}, 32'h0);
        chk("midrst_ov", {31'h0, operands_valid}, 32'h1);

        // Randomized run against the model
        do_reset();
        model_reset();
        for (int c = 0; c < 500; c++) begin
            int r;
            r = $urandom_range(0, 9);
            enable           = ($urandom_range(0, 9) != 0);
            core_state       = (r < 5) ? R : (r < 9) ? U : I;
            vector_mux       = 1'($urandom_range(0, 1));
            reg_write_enable = ($urandom_range(0, 4) != 0);
            reg_input_mux    = 2'($urandom_range(0, 3));
            rd_addr = raddr(); rs_addr = raddr(); rt_addr = raddr();
            immediate = 8'($urandom); alu_out = 8'($urandom); v_alu_out = $urandom;
            lane_mask = 4'($urandom_range(0, 15));
            lsu_wb_valid  = ($urandom_range(0, 4) < 2);
            lsu_wb_vector = 1'($urandom_range(0, 1));
            lsu_wb_addr   = raddr();
            lsu_wb_data   = $urandom;
            e_hz  = exp_hazard();
            e_rdy = exp_ready();
            @(negedge clk);
            chk($sformatf("rnd%0d_hazard", c), {31'h0, hazard}, {31'h0, e_hz});
            chk($sformatf("rnd%0d_ready", c), {31'h0, lsu_wb_ready}, {31'h0, e_rdy});
            model_update();
            @(posedge clk); #1;
            chk($sformatf("rnd%0d_rs", c), {24'h0, rs}, {24'h0, m_rs});
            chk($sformatf("rnd%0d_rt", c), {24'h0, rt}, {24'h0, m_rt});
            chk($sformatf("rnd%0d_v_rs", c), v_rs, m_vrs);
            chk($sformatf("rnd%0d_v_rt", c), v_rt, m_vrt);
            chk($sformatf("rnd%0d_ov", c), {31'h0, operands_valid}, {31'h0, m_ov});
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
